// File: rtl/rgb_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgb_mixer_pkg
// Purpose  : Shared level width, debounce default and step direction type
//            for the rgb_mixer encoder front-ends and PWM generators.
// Revision : 1.0
// ============================================================================
package rgb_mixer_pkg;

    localparam int LEVEL_WIDTH      = 8;
    localparam int DEFAULT_DEBOUNCE = 16;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2
    } step_dir_t;

endpackage : rgb_mixer_pkg
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce
// Purpose  : Two-flop synchroniser followed by a stability counter; the output
//            level follows the input only after DEBOUNCE_CYCLES stable samples.
// Revision : 1.0
// ============================================================================
module input_debounce
    import rgb_mixer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int              c_cnt_w    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the current level restarts the stability run.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dout = r_level;

endmodule : input_debounce
`default_nettype wire

// File: rtl/quad_encoder_counter.sv
`default_nettype none
// ============================================================================
// Module   : quad_encoder_counter
// Purpose  : Debounced x1 quadrature decoder driving a wrapping or clamping
//            level register with one-cycle up/down step strobes.
// Revision : 1.0
// ============================================================================
module quad_encoder_counter
    import rgb_mixer_pkg::*;
#(
    parameter int WIDTH           = LEVEL_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int STEP            = 1,
    parameter int SATURATE        = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             en,
    output logic [WIDTH-1:0] value,
    output logic             step_up,
    output logic             step_dn
);

    localparam logic [WIDTH:0] c_step = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0] c_max  = {1'b0, {WIDTH{1'b1}}};

    logic [1:0]       w_raw;
    logic [1:0]       w_deb;
    logic             r_a_prev;
    logic [WIDTH-1:0] r_value;
    logic             r_step_up;
    logic             r_step_dn;
    step_dir_t        w_dir;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_next;

    assign w_raw = {enc_b, enc_a};

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (w_raw[gi]),
            .dout (w_deb[gi])
        );
    end

    // Only the rising edge of debounced A is a detent; B picks the direction.
    always_comb begin
        w_dir = STEP_NONE;
        if (w_deb[0] && !r_a_prev) begin
            w_dir = w_deb[1] ? STEP_DN : STEP_UP;
        end
    end

    assign w_sum  = {1'b0, r_value} + c_step;
    assign w_diff = {1'b0, r_value} - c_step;

    // The extra top bit flags overflow on the sum and borrow on the difference.
    always_comb begin
        w_next = r_value;
        case (w_dir)
            STEP_UP: begin
                if ((SATURATE != 0) && (w_sum > c_max)) begin
                    w_next = c_max[WIDTH-1:0];
                end else begin
                    w_next = w_sum[WIDTH-1:0];
                end
            end
            STEP_DN: begin
                if ((SATURATE != 0) && w_diff[WIDTH]) begin
                    w_next = '0;
                end else begin
                    w_next = w_diff[WIDTH-1:0];
                end
            end
            default: w_next = r_value;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_prev  <= 1'b0;
            r_value   <= '0;
            r_step_up <= 1'b0;
            r_step_dn <= 1'b0;
        end else begin
            r_a_prev  <= w_deb[0];
            r_step_up <= 1'b0;
            r_step_dn <= 1'b0;
            if (en && (w_dir != STEP_NONE)) begin
                r_value   <= w_next;
                r_step_up <= (w_dir == STEP_UP);
                r_step_dn <= (w_dir == STEP_DN);
            end
        end
    end

    assign value   = r_value;
    assign step_up = r_step_up;
    assign step_dn = r_step_dn;

endmodule : quad_encoder_counter
`default_nettype wire

// File: tb/tb_quad_encoder_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_encoder_counter
// Purpose  : Four parameter variants driven in parallel, checked every cycle
//            against a sample-history reference model plus literal checks.
// Revision : 1.0
// ============================================================================
module tb_quad_encoder_counter;

    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic enc_a = 1'b1;
    logic enc_b = 1'b1;
    logic en    = 1'b1;

    logic [3:0][7:0] dv;
    logic [3:0]      dup;
    logic [3:0]      ddn;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    quad_encoder_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .STEP(1),  .SATURATE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .en(en),
        .value(dv[0]), .step_up(dup[0]), .step_dn(ddn[0]));
    quad_encoder_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .STEP(1),  .SATURATE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .en(en),
        .value(dv[1]), .step_up(dup[1]), .step_dn(ddn[1]));
    quad_encoder_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .STEP(16), .SATURATE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .en(en),
        .value(dv[2]), .step_up(dup[2]), .step_dn(ddn[2]));
    quad_encoder_counter #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .STEP(16), .SATURATE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .en(en),
        .value(dv[3]), .step_up(dup[3]), .step_dn(ddn[3]));

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_step[4] = '{1, 1, 16, 16};
    int m_sat[4]  = '{0, 1, 0, 1};
    int mv[4];
    bit mu[4];
    bit md[4];
    bit raw_a[$];
    bit raw_b[$];
    bit hist_a[$];
    bit hist_b[$];
    bit deb_a, deb_b, prev_a;

    // Debounced level flips once the last D synchronised samples all disagree with it.
    function automatic bit all_differ(input bit q[$], input bit lvl);
        if (q.size() < D) return 1'b0;
        foreach (q[i]) if (q[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit det;
        bit down;
        int nv;
        if (!rst_n) begin
            raw_a = '{1'b0, 1'b0};
            raw_b = '{1'b0, 1'b0};
            hist_a.delete();
            hist_b.delete();
            for (int i = 0; i < D; i++) begin
                hist_a.push_back(1'b0);
                hist_b.push_back(1'b0);
            end
            deb_a = 0; deb_b = 0; prev_a = 0;
            for (int i = 0; i < 4; i++) begin mv[i] = 0; mu[i] = 0; md[i] = 0; end
        end else begin
            det  = deb_a && !prev_a;
            down = deb_b;
            for (int i = 0; i < 4; i++) begin
                mu[i] = 0;
                md[i] = 0;
                if (det && en) begin
                    if (!down) begin
                        mu[i] = 1;
                        nv = mv[i] + m_step[i];
                        mv[i] = m_sat[i] != 0 ? (nv > 255 ? 255 : nv) : nv % 256;
                    end else begin
                        md[i] = 1;
                        nv = mv[i] - m_step[i];
                        mv[i] = m_sat[i] != 0 ? (nv < 0 ? 0 : nv) : (nv + 256) % 256;
                    end
                end
            end
            prev_a = deb_a;
            // Synchroniser delay: the debouncer sees the raw sample from two edges ago.
            hist_a.push_back(raw_a.pop_front());
            hist_b.push_back(raw_b.pop_front());
            if (hist_a.size() > D) void'(hist_a.pop_front());
            if (hist_b.size() > D) void'(hist_b.pop_front());
            if (all_differ(hist_a, deb_a)) deb_a = !deb_a;
            if (all_differ(hist_b, deb_b)) deb_b = !deb_b;
            raw_a.push_back(enc_a);
            raw_b.push_back(enc_b);
        end
    end

    int cnt_up[4] = '{0, 0, 0, 0};
    int cnt_dn[4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            check($sformatf("value[%0d]", i), dv[i], mv[i]);
            check($sformatf("step_up[%0d]", i), dup[i], mu[i]);
            check($sformatf("step_dn[%0d]", i), ddn[i], md[i]);
            if (dup[i]) cnt_up[i]++;
            if (ddn[i]) cnt_dn[i]++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (D + 6) tick();
    endtask

    task automatic detent(input bit down);
        enc_b = down;
        repeat (D + 4) tick();
        enc_a = 1'b1;
        repeat (D + 6) tick();
        enc_a = 1'b0;
        repeat (D + 6) tick();
    endtask

    int su[4];
    int sd[4];

    task automatic snap();
        for (int i = 0; i < 4; i++) begin su[i] = cnt_up[i]; sd[i] = cnt_dn[i]; end
    endtask

    initial begin
        // 1: reset with both pins high, then idle low
        repeat (2) tick();
        check("rst value0", dv[0], 0);
        check("rst value3", dv[3], 0);
        check("rst step_up", dup[0], 0);
        check("rst step_dn", ddn[0], 0);
        enc_a = 1'b0; enc_b = 1'b0;
        rst_n = 1'b1;
        snap();
        repeat (20) tick();
        check("idle strobes", cnt_up[0] + cnt_dn[0] - su[0] - sd[0], 0);

        // 2: clean CW detent, strobe exactly at t0+7
        enc_a = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("cw step_up t0+%0d", i), dup[0], (i == 7) ? 1 : 0);
        end
        repeat (10) tick();
        check("cw value", dv[0], 1);
        enc_a = 1'b0;
        repeat (D + 6) tick();

        // 3: bounce rejection, single down detent
        do_reset();
        enc_b = 1'b1;
        repeat (D + 4) tick();
        snap();
        for (int k = 0; k < 10; k++) begin
            enc_a = ~enc_a;
            repeat (2) tick();
        end
        enc_a = 1'b1;
        repeat (D + 8) tick();
        check("bounce dn count wrap", cnt_dn[0] - sd[0], 1);
        check("bounce dn count sat", cnt_dn[1] - sd[1], 1);
        check("bounce up count", cnt_up[0] - su[0], 0);
        check("bounce value wrap", dv[0], 255);
        check("bounce value sat", dv[1], 0);
        enc_a = 1'b0;
        repeat (D + 6) tick();

        // 4: STEP=16 wrap and clamp
        do_reset();
        repeat (15) detent(1'b0);
        check("step16 wrap 15", dv[2], 240);
        check("step16 sat 15", dv[3], 240);
        detent(1'b0);
        check("step16 wrap 16", dv[2], 0);
        check("step16 sat 16", dv[3], 255);
        snap();
        detent(1'b0);
        check("step16 wrap 17", dv[2], 16);
        check("step16 sat 17", dv[3], 255);
        check("step16 sat strobe", cnt_up[3] - su[3], 1);
        repeat (3) detent(1'b0);
        check("step16 sat 20", dv[3], 255);

        // 5: enable gating
        en = 1'b0;
        snap();
        repeat (3) detent(1'b0);
        check("en0 value", dv[0], 20);
        check("en0 strobes", cnt_up[0] + cnt_dn[0] - su[0] - sd[0], 0);
        en = 1'b1;
        detent(1'b0);
        check("en1 value", dv[0], 21);

        // 6: reset in the middle of a pending edge
        do_reset();
        snap();
        enc_b = 1'b0;
        enc_a = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        enc_a = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("midrst strobes", cnt_up[0] + cnt_dn[0] - su[0] - sd[0], 0);
        check("midrst value", dv[0], 0);

        // random phase: bounces, direction changes, enable and reset noise
        for (int s = 0; s < 400; s++) begin
            int mode;
            mode = $urandom_range(0, 19);
            if (mode == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else if (mode < 5) begin
                for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                    enc_a = ~enc_a;
                    repeat ($urandom_range(1, 3)) tick();
                end
            end else begin
                enc_a = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) enc_b = 1'($urandom_range(0, 1));
                en = ($urandom_range(0, 7) != 0);
                repeat ($urandom_range(1, 12)) tick();
            end
        end
        en = 1'b1;
        repeat (D + 6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_quad_encoder_counter
`default_nettype wire
